pipelined_barrel_right_shifter: RTL and testbench
=================================================

# pipelined_barrel_right_shifter

Variable-amount right shifter for the arithmetic datapath: a parameterized barrel shifter, pipelined one stage per shift-amount bit, with valid/ready flow control on both sides. It complements the fixed-amount combinational shifters by supporting a runtime shift amount and a selectable logical or arithmetic (sign-filling) mode. It sits between a producer of operands and a consumer that may apply backpressure.

## Interface
- N, 8, data width; power of two, at least 2.
- SW, $clog2(N), shift-amount width and pipeline depth; derived, not overridden.

- clk  input  1  clock; all state on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- up_vld  input  1  input operand valid.
- up_rdy  output  1  block can accept an operand this cycle.
- up_data  input  N  operand.
- up_shamt  input  SW  shift amount, 0..N-1.
- up_arith  input  1  1 = arithmetic (fill with up_data[N-1]), 0 = logical (fill with 0).
- down_vld  output  1  result valid.
- down_rdy  input  1  consumer accepts the result.
- down_data  output  N  shifted result.

## Operation
- SW register stages, numbered 0..SW-1. Stage k applies a shift of 2^k when shamt bit k is set, else passes data through.
- Each stage holds a valid flag, data, the remaining shamt bits, the arith flag and the fill bit. The fill bit is captured once from up_data[N-1] at entry, so later stages never re-derive sign.
- Fill value = fill bit if arith, else 0.
- A stage advances when it is empty or its successor advances: rdy_k = !vld_k || rdy_(k+1), and rdy_SW = down_rdy. up_rdy = rdy_0. The combinational path down_rdy -> up_rdy is allowed.
- Transfer occurs when vld && rdy on either port. No reordering, duplication or loss. A stage whose predecessor is empty goes invalid when it advances (bubble).
- down_vld = vld_(SW-1), and down_data = data_(SW-1).
- shamt 0 yields up_data unchanged in both modes.
- The shamt range is fully legal (N-1 max), so there is no overflow case.
- Reset (asserted any time, including mid-stream): all valid flags clear immediately. Data registers are 0. In-flight operands are discarded and not flushed out.
- Reset values of the outputs: down_vld 0, down_data 0, up_rdy 1.

## Timing
- Latency: an operand accepted on edge t appears with down_vld = 1 after edge t+SW-1, so SW cycles, i.e. 3 for N = 8.
- Throughput: one operand per cycle while down_rdy = 1.
- With down_rdy = 0, the pipeline fills. After SW accepted operands, up_rdy = 0 until down_rdy returns.
- Simultaneous accept at input and drain at output in the same cycle is allowed when full. up_rdy follows down_rdy in the same cycle.
- While down_vld = 1 and down_rdy = 0, down_data stays stable.
- Release of rst_n is synchronous to clk at the user's side. The first accept is possible on the first edge after release.

## Structure
- Package shifter_pkg holds:
  - a function fill_shift(data, amount, fill) returning the N-bit shifted value, shared with the bench model;
  - the stage payload struct type: data, shamt, arith, fill.
- Sub-module shift_stage, parameters N and K. It contains:
  - one register slice applying a conditional shift of 2^K;
  - its valid flag and the rdy chain logic.
- The top level instantiates shift_stage in a generate loop over K = 0..SW-1.

## Test plan
- Logical right shift, N = 8: up_data 8'b1011_0000, shamt 3, arith 0 -> down_data 8'b0001_0110, appearing 3 cycles after accept.
- Arithmetic right shift, N = 8:
  - 8'b1011_0000, shamt 3, arith 1 -> 8'b1111_0110;
  - 8'h80, shamt 7, arith 1 -> 8'hFF;
  - 8'h7F, shamt 7, arith 1 -> 8'h00.
- Shamt 0 sweep: random data, both modes -> output equals input.
- Backpressure: hold down_rdy = 0 and offer 5 operands back-to-back. Required:
  - up_rdy drops after exactly 3 accepts;
  - down_data is held stable while stalled;
  - after release, results arrive in order, one per cycle.
- Streaming with random up_vld and down_rdy, 1000 operands, N = 8 and N = 32 -> every result matches fill_shift, with no loss, duplication or reordering.
- Reset mid-stream: assert rst_n = 0 with 3 operands in flight. Required:
  - down_vld goes to 0 immediately, without waiting for clk;
  - up_rdy = 1;
  - no stale result appears after reset is released.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel right shifter.
// - MaxN / MaxSw : widest supported data width and shift-amount width.
// - stage_t      : per-stage payload (data, remaining shift amount, mode, fill bit).
// - fill_shift   : right shift of the low `width` bits, filling vacated bits with `fill`.
package shifter_pkg;

    // Payload fields are sized for the widest configuration; narrower
    // instances keep the unused upper bits at zero so synthesis removes them.
    // Instances must use N <= MaxN.
    localparam int unsigned MaxN  = 64;
    localparam int unsigned MaxSw = 6;

    typedef struct packed {
        logic [MaxN-1:0]  data;
        logic [MaxSw-1:0] shamt;
        logic             arith;
        logic             fill;
    } stage_t;

    // Shifts data[width-1:0] right by amount. The vacated top bits of the
    // width-bit field are set to fill, and bits above width are cleared.
    function automatic logic [MaxN-1:0] fill_shift(input logic [MaxN-1:0] data,
                                                   input int unsigned     amount,
                                                   input logic            fill,
                                                   input int unsigned     width);
        logic [MaxN-1:0] mask;
        logic [MaxN-1:0] res;
        mask = (width >= MaxN) ? '1 : ((MaxN'(1) << width) - MaxN'(1));
        res  = (data & mask) >> amount;
        if (fill) begin
            res = res | (mask & ~(mask >> amount));
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice of the barrel right shifter.
// Applies a shift of 2^K when shamt bit K of the incoming payload is set.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_vld / in_rdy         handshake from the previous stage (or the producer)
//   in_payload              incoming payload
//   out_vld / out_rdy       handshake to the next stage (or the consumer)
//   out_payload             registered payload
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned K = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_vld,
    output logic   in_rdy,
    input  stage_t in_payload,
    output logic   out_vld,
    input  logic   out_rdy,
    output stage_t out_payload
);

    localparam int unsigned Step = 32'd1 << K;

    logic   vld_q;
    stage_t payload_d;
    stage_t payload_q;

    // Fill only applies in arithmetic mode; the fill bit itself was captured
    // at entry so the sign is never re-derived from already-shifted data.
    always_comb begin
        payload_d = in_payload;
        if (in_payload.shamt[K]) begin
            payload_d.data = fill_shift(in_payload.data, Step,
                                        in_payload.arith & in_payload.fill, N);
        end
    end

    // The slice can take new data when empty or when its contents move on.
    assign in_rdy = !vld_q || out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            payload_q <= '0;
        end else if (in_rdy) begin
            vld_q <= in_vld;
            if (in_vld) begin
                payload_q <= payload_d;
            end
        end
    end

    assign out_vld     = vld_q;
    assign out_payload = payload_q;

endmodule

// File: rtl/pipelined_barrel_right_shifter.sv
// Variable-amount right shifter, one register stage per shift-amount bit,
// with valid/ready flow control on both sides. Latency SW cycles, one
// operand per cycle when the consumer is ready.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   up_vld / up_rdy                operand handshake
//   up_data, up_shamt, up_arith    operand, shift amount, 1 = sign fill
//   down_vld / down_rdy            result handshake
//   down_data                      shifted result
module pipelined_barrel_right_shifter
    import shifter_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_arith,
    output logic          down_vld,
    input  logic          down_rdy,
    output logic [N-1:0]  down_data
);

    stage_t entry_payload;

    always_comb begin
        entry_payload       = '0;
        entry_payload.data  = MaxN'(up_data);
        entry_payload.shamt = MaxSw'(up_shamt);
        entry_payload.arith = up_arith;
        entry_payload.fill  = up_data[N-1];
    end

    // Each stage keeps its own link signals so the ready chain is not a
    // self-dependent vector.
    for (genvar k = 0; k < SW; k++) begin : gen_stage
        logic   in_vld;
        logic   in_rdy;
        logic   out_vld;
        logic   out_rdy;
        stage_t in_pl;
        stage_t out_pl;

        if (k == 0) begin : gen_head
            assign in_vld = up_vld;
            assign in_pl  = entry_payload;
        end else begin : gen_link
            assign in_vld = gen_stage[k-1].out_vld;
            assign in_pl  = gen_stage[k-1].out_pl;
        end

        if (k == SW - 1) begin : gen_tail
            assign out_rdy = down_rdy;
        end else begin : gen_mid
            assign out_rdy = gen_stage[k+1].in_rdy;
        end

        shift_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_vld      (in_vld),
            .in_rdy      (in_rdy),
            .in_payload  (in_pl),
            .out_vld     (out_vld),
            .out_rdy     (out_rdy),
            .out_payload (out_pl)
        );
    end

    stage_t last_payload;

    assign last_payload = gen_stage[SW-1].out_pl;
    assign up_rdy       = gen_stage[0].in_rdy;
    assign down_vld     = gen_stage[SW-1].out_vld;
    assign down_data    = last_payload.data[N-1:0];

    // Control fields and upper data bits are spent by the last stage.
    logic unused_last;
    assign unused_last = ^{last_payload.data, last_payload.shamt,
                           last_payload.arith, last_payload.fill};

endmodule

// File: tb/tb_pipelined_barrel_right_shifter.sv
module tb_pipelined_barrel_right_shifter;

    localparam int unsigned NA  = 8;
    localparam int unsigned SWA = 3;
    localparam int unsigned NB  = 32;
    localparam int unsigned SWB = 5;
    localparam int unsigned Ops = 1000;

    typedef logic [63:0] word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           a_up_vld, a_up_rdy, a_up_arith, a_down_vld, a_down_rdy;
    logic [NA-1:0]  a_up_data, a_down_data;
    logic [SWA-1:0] a_up_shamt;
    logic           b_up_vld, b_up_rdy, b_up_arith, b_down_vld, b_down_rdy;
    logic [NB-1:0]  b_up_data, b_down_data;
    logic [SWB-1:0] b_up_shamt;

    pipelined_barrel_right_shifter #(.N(NA)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_vld    (a_up_vld),
        .up_rdy    (a_up_rdy),
        .up_data   (a_up_data),
        .up_shamt  (a_up_shamt),
        .up_arith  (a_up_arith),
        .down_vld  (a_down_vld),
        .down_rdy  (a_down_rdy),
        .down_data (a_down_data)
    );

    pipelined_barrel_right_shifter #(.N(NB)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_vld    (b_up_vld),
        .up_rdy    (b_up_rdy),
        .up_data   (b_up_data),
        .up_shamt  (b_up_shamt),
        .up_arith  (b_up_arith),
        .down_vld  (b_down_vld),
        .down_rdy  (b_down_rdy),
        .down_data (b_down_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    word_t       qa[$];
    word_t       qb[$];

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: bit i of the result is bit i+amt of the operand, or the fill.
    function automatic word_t ref_shift(input word_t d, input int amt, input logic arith,
                                        input int w);
        word_t r;
        logic  s;
        r = '0;
        s = arith & d[w-1];
        for (int i = 0; i < w; i++) r[i] = (i + amt < w) ? d[i+amt] : s;
        return r;
    endfunction

    task automatic directed_a(input string tag, input logic [7:0] d, input int sh,
                              input logic ar, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        a_up_vld   = 1'b1;
        a_up_data  = d;
        a_up_shamt = sh[2:0];
        a_up_arith = ar;
        a_down_rdy = 1'b1;
        #1 check({tag, "_up_rdy"}, a_up_rdy, 1);
        @(negedge clk);
        a_up_vld = 1'b0;
        lat = 1;
        #1;
        while (!a_down_vld && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, a_down_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  bp_d [5];
        int          bp_s [5];
        logic        bp_a [5];
        int          sent, got, cyc, sa, ra, sb, rb;
        int unsigned r;
        logic [7:0]  dd;

        rst_n = 1'b0;
        a_up_vld = 0; a_up_data = 0; a_up_shamt = 0; a_up_arith = 0; a_down_rdy = 0;
        b_up_vld = 0; b_up_data = 0; b_up_shamt = 0; b_up_arith = 0; b_down_rdy = 0;
        #12;
        check("rst_a_down_vld", a_down_vld, 0);
        check("rst_a_down_data", a_down_data, 0);
        check("rst_a_up_rdy", a_up_rdy, 1);
        check("rst_b_down_vld", b_down_vld, 0);
        check("rst_b_up_rdy", b_up_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;

        directed_a("lsr_b0_3", 8'hB0, 3, 1'b0, 8'h16);
        directed_a("asr_b0_3", 8'hB0, 3, 1'b1, 8'hF6);
        directed_a("asr_80_7", 8'h80, 7, 1'b1, 8'hFF);
        directed_a("asr_7f_7", 8'h7F, 7, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            r  = $urandom;
            dd = r[7:0];
            directed_a("shamt0", dd, 0, r[8], dd);
        end

        // Backpressure: consumer stalled, five operands offered back-to-back.
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            bp_d[i] = r[7:0];
            bp_s[i] = int'(r[10:8]);
            bp_a[i] = r[11];
        end
        qa.delete();
        sent = 0;
        got  = 0;
        @(negedge clk);
        a_down_rdy = 1'b0;
        repeat (6) begin
            @(negedge clk);
            a_up_vld = (sent < 5);
            if (sent < 5) begin
                a_up_data = bp_d[sent]; a_up_shamt = bp_s[sent][2:0]; a_up_arith = bp_a[sent];
            end
            #1;
            if (a_up_vld && a_up_rdy) begin
                qa.push_back(ref_shift(word_t'(bp_d[sent]), bp_s[sent], bp_a[sent], NA));
                sent++;
            end
        end
        check("bp_accepts", sent, 3);
        check("bp_up_rdy_low", a_up_rdy, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_hold_vld", a_down_vld, 1);
            check("bp_hold_data", a_down_data, qa[0]);
        end
        cyc = 0;
        while (got < 5 && cyc < 30) begin
            @(negedge clk);
            a_down_rdy = 1'b1;
            a_up_vld   = (sent < 5);
            if (sent < 5) begin
                a_up_data = bp_d[sent]; a_up_shamt = bp_s[sent][2:0]; a_up_arith = bp_a[sent];
            end
            #1;
            if (cyc == 0) check("bp_rdy_follow", a_up_rdy, 1);
            check("bp_stream_vld", a_down_vld, 1);
            if (a_up_vld && a_up_rdy) begin
                qa.push_back(ref_shift(word_t'(bp_d[sent]), bp_s[sent], bp_a[sent], NA));
                sent++;
            end
            if (a_down_vld) begin
                if (qa.size() == 0) check("bp_extra", 1, 0);
                else begin
                    check("bp_order", a_down_data, qa.pop_front());
                    got++;
                end
            end
            cyc++;
        end
        check("bp_got", got, 5);
        @(negedge clk);
        a_up_vld = 1'b0;

        // Random streaming on both widths at once.
        repeat (5) @(negedge clk);
        qa.delete();
        qb.delete();
        sa = 0; ra = 0; sb = 0; rb = 0; cyc = 0;
        while ((ra < Ops || rb < Ops) && cyc < 20000) begin
            @(negedge clk);
            r = $urandom;
            a_up_vld   = (sa < Ops) && (r[1:0] != 2'b00);
            a_down_rdy = (r[3:2] != 2'b00);
            a_up_data  = r[15:8];
            a_up_shamt = r[18:16];
            a_up_arith = r[19];
            b_up_vld   = (sb < Ops) && (r[21:20] != 2'b00);
            b_down_rdy = (r[23:22] != 2'b00);
            b_up_shamt = r[28:24];
            b_up_arith = r[29];
            b_up_data  = $urandom;
            #1;
            if (a_down_vld) begin
                if (qa.size() == 0) check("a_extra", 1, 0);
                else begin
                    check("a_data", a_down_data, qa[0]);
                    if (a_down_rdy) begin
                        void'(qa.pop_front());
                        ra++;
                    end
                end
            end
            if (a_up_vld && a_up_rdy) begin
                qa.push_back(ref_shift(word_t'(a_up_data), int'(a_up_shamt), a_up_arith, NA));
                sa++;
            end
            if (b_down_vld) begin
                if (qb.size() == 0) check("b_extra", 1, 0);
                else begin
                    check("b_data", b_down_data, qb[0]);
                    if (b_down_rdy) begin
                        void'(qb.pop_front());
                        rb++;
                    end
                end
            end
            if (b_up_vld && b_up_rdy) begin
                qb.push_back(ref_shift(word_t'(b_up_data), int'(b_up_shamt), b_up_arith, NB));
                sb++;
            end
            cyc++;
        end
        check("a_count", ra, Ops);
        check("b_count", rb, Ops);
        @(negedge clk);
        a_up_vld = 1'b0; b_up_vld = 1'b0; a_down_rdy = 1'b1; b_down_rdy = 1'b1;
        repeat (6) @(negedge clk);
        #1 check("a_drained", a_down_vld, 0);

        // Reset with three operands in flight.
        @(negedge clk);
        a_down_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_up_vld = 1'b1; a_up_data = 8'h90 + 8'(i); a_up_shamt = 3'd1; a_up_arith = 1'b1;
            @(negedge clk);
        end
        a_up_vld = 1'b0;
        #2 check("pre_rst_full", a_down_vld, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_down_vld", a_down_vld, 0);
        check("rst_mid_up_rdy", a_up_rdy, 1);
        check("rst_mid_down_data", a_down_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_down_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1 check("rst_no_stale", a_down_vld, 0);
        end
        directed_a("post_rst", 8'hB0, 3, 1'b1, 8'hF6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
